// File: rtl/simple_mem_target_if.sv
// Word-addressed CPU memory bus: initiator strobes re/we/addr/wdata,
// target answers with a one-cycle mem_ready plus rdata.
interface simple_mem_target_if;
  logic        re;
  logic [3:0]  we;
  logic [29:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        mem_ready;
  logic        overrun;

  modport master (
    output re, we, addr, wdata,
    input  rdata, mem_ready, overrun
  );

  modport slave (
    input  re, we, addr, wdata,
    output rdata, mem_ready, overrun
  );
endinterface

// File: rtl/simple_mem_target.sv
// Memory responder with per-byte-lane RAM slices and WAIT_STATES cycles of
// programmable latency between acceptance and mem_ready.

module simple_mem_lane #(
  parameter int ADDR_BITS = 10,
  parameter int VEC_W     = 8
) (
  input  logic                 clk,
  input  logic                 en,
  input  logic                 rd,
  input  logic                 wr,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [VEC_W-1:0]     wdata,
  output logic [VEC_W-1:0]     rdata
);
  logic [VEC_W-1:0] mem [2**ADDR_BITS];

  // Single access port, touched only on acceptance edges so a BRAM maps cleanly.
  always_ff @(posedge clk) begin
    if (en) begin
      if (wr) mem[addr] <= wdata;
      if (rd) rdata     <= mem[addr];
    end
  end
endmodule

module simple_mem_target #(
  parameter int ADDR_BITS   = 10,
  parameter int WAIT_STATES = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  simple_mem_target_if.slave   bus
);
  localparam int NUM_LANES = 4;
  localparam int VEC_W     = 8;
  localparam logic [3:0] WS_LOAD = 4'((WAIT_STATES == 0) ? 0 : WAIT_STATES - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       accept;
  logic       is_rd;
  logic       rd_pend;
  logic       ovr;
  logic [31:0] rdata_q;
  logic [NUM_LANES-1:0][VEC_W-1:0] rd_word;
  logic       unused_addr_hi;

  assign accept         = bus.re && (state != S_WAIT);
  assign is_rd          = (bus.we == 4'b0000);
  assign unused_addr_hi = ^bus.addr[29:ADDR_BITS];

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    simple_mem_lane #(
      .ADDR_BITS (ADDR_BITS),
      .VEC_W     (VEC_W)
    ) u_lane (
      .clk   (clk),
      .en    (accept),
      .rd    (is_rd),
      .wr    (bus.we[i]),
      .addr  (bus.addr[ADDR_BITS-1:0]),
      .wdata (bus.wdata[i*VEC_W +: VEC_W]),
      .rdata (rd_word[i])
    );
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE, S_RESP: begin
        if (accept) begin
          if (WAIT_STATES == 0) begin
            state_nxt = S_RESP;
          end else begin
            state_nxt = S_WAIT;
            cnt_nxt   = WS_LOAD;
          end
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_WAIT: begin
        if (cnt == 4'd0) state_nxt = S_RESP;
        else             cnt_nxt   = cnt - 4'd1;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      cnt     <= 4'd0;
      rd_pend <= 1'b0;
      rdata_q <= 32'd0;
      ovr     <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) rd_pend <= is_rd;
      // Latch the completing read so rdata holds it through later writes.
      if (state == S_RESP && rd_pend) rdata_q <= rd_word;
      if (bus.re && state == S_WAIT) ovr <= 1'b1;
    end
  end

  assign bus.mem_ready = (state == S_RESP);
  assign bus.rdata     = (state == S_RESP && rd_pend) ? 32'(rd_word) : rdata_q;
  assign bus.overrun   = ovr;
endmodule

// File: tb/tb_simple_mem_target.sv
// Randomized scoreboard bench: two targets (0 and 3 wait states) driven
// against a word-array reference model with timing and overrun tracking.
module tb_simple_mem_target;
  logic clk = 1'b0;
  logic reset0 = 1'b0;
  logic reset3 = 1'b0;
  int   cyc = 0;
  int   n_tot = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  simple_mem_target_if b0();
  simple_mem_target_if b3();

  simple_mem_target #(.ADDR_BITS(10), .WAIT_STATES(0)) u0 (.clk(clk), .reset(reset0), .bus(b0));
  simple_mem_target #(.ADDR_BITS(10), .WAIT_STATES(3)) u3 (.clk(clk), .reset(reset3), .bus(b3));

  typedef struct {
    int          due;
    bit          rd;
    logic [31:0] data;
  } exp_t;

  exp_t        q0[$];
  exp_t        q3[$];
  logic [31:0] mdl [2][1024];
  int          last_acc [2] = '{-100, -100};
  bit          exp_ovr [2]  = '{1'b0, 1'b0};
  logic [31:0] last_rd [2]  = '{32'd0, 32'd0};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive one transaction for one cycle and update the reference model.
  task automatic issue(input int s, input logic [3:0] we, input logic [29:0] addr,
                       input logic [31:0] wd);
    int   c  = cyc;
    int   ws = (s == 0) ? 0 : 3;
    int   idx = int'(addr[9:0]);
    exp_t e;
    if (s == 0) begin b0.re = 1'b1; b0.we = we; b0.addr = addr; b0.wdata = wd; end
    else        begin b3.re = 1'b1; b3.we = we; b3.addr = addr; b3.wdata = wd; end
    if (c > last_acc[s] && c <= last_acc[s] + ws) begin
      exp_ovr[s] = 1'b1;
    end else begin
      last_acc[s] = c;
      for (int i = 0; i < 4; i++)
        if (we[i]) mdl[s][idx][8*i +: 8] = wd[8*i +: 8];
      e.due  = c + ws + 1;
      e.rd   = (we == 4'b0000);
      e.data = mdl[s][idx];
      if (s == 0) q0.push_back(e); else q3.push_back(e);
    end
    @(posedge clk);
    #1;
    if (s == 0) b0.re = 1'b0; else b3.re = 1'b0;
  endtask

  task automatic mon_step(input int s, input logic rdy, input logic [31:0] rd,
                          input logic ovr);
    exp_t e;
    int   qs = (s == 0) ? q0.size() : q3.size();
    if (qs > 0) begin
      e = (s == 0) ? q0[0] : q3[0];
      if (e.due < cyc) begin
        chk($sformatf("missing_ready%0d", s), 32'(rdy), 32'd1);
        if (s == 0) void'(q0.pop_front()); else void'(q3.pop_front());
        qs--;
      end
    end
    if (rdy) begin
      if (qs == 0) begin
        chk($sformatf("spurious_ready%0d", s), 32'(rdy), 32'd0);
      end else begin
        if (s == 0) e = q0.pop_front(); else e = q3.pop_front();
        chk($sformatf("latency%0d", s), cyc, e.due);
        if (e.rd) begin
          chk($sformatf("rdata%0d", s), rd, e.data);
          last_rd[s] = e.data;
        end else begin
          chk($sformatf("rdata_hold%0d", s), rd, last_rd[s]);
        end
        chk($sformatf("overrun%0d", s), 32'(ovr), 32'(exp_ovr[s]));
      end
    end
  endtask

  always @(negedge clk) if (reset0) mon_step(0, b0.mem_ready, b0.rdata, b0.overrun);
  always @(negedge clk) if (reset3) mon_step(1, b3.mem_ready, b3.rdata, b3.overrun);

  initial begin
    b0.re = 1'b0; b0.we = 4'h0; b0.addr = '0; b0.wdata = '0;
    b3.re = 1'b0; b3.we = 4'h0; b3.addr = '0; b3.wdata = '0;
    idle(3);
    reset0 = 1'b1;
    reset3 = 1'b1;
    idle(1);

    chk("rst_ready0", 32'(b0.mem_ready), 32'd0);
    chk("rst_rdata0", b0.rdata, 32'd0);
    chk("rst_ovr0",   32'(b0.overrun), 32'd0);
    chk("rst_ready3", 32'(b3.mem_ready), 32'd0);
    chk("rst_rdata3", b3.rdata, 32'd0);
    chk("rst_ovr3",   32'(b3.overrun), 32'd0);
    idle(20);

    // Zero wait states: write then read in the write's RESP cycle.
    issue(0, 4'hF, 30'd5, 32'hDEADBEEF);
    issue(0, 4'h0, 30'd5, 32'h0);
    idle(2);
    chk("raw_b2b", b0.rdata, 32'hDEADBEEF);

    issue(0, 4'hF, 30'd7, 32'h11223344);
    issue(0, 4'h5, 30'd7, 32'hAABBCCDD);
    issue(0, 4'h0, 30'd7, 32'h0);
    idle(2);
    chk("byte_lanes", b0.rdata, 32'h11BB33DD);

    issue(0, 4'hF, 30'd3, 32'h0000CAFE);
    issue(0, 4'h0, 30'd1027, 32'h0);
    idle(2);
    chk("alias", b0.rdata, 32'h0000CAFE);

    for (int a = 0; a < 16; a++) begin
      issue(0, 4'hF, 30'(a), $urandom());
      issue(1, 4'hF, 30'(a), $urandom());
      idle(3);
    end
    chk("ovr3_clean", 32'(b3.overrun), 32'd0);

    // Three wait states: busy strobe at +2 is dropped and flags overrun.
    issue(1, 4'hF, 30'd5, 32'hDEADBEEF);
    idle(3);
    issue(1, 4'h0, 30'd5, 32'h0);
    idle(1);
    issue(1, 4'h0, 30'd5, 32'h0);
    idle(4);
    chk("ws3_rdata", b3.rdata, 32'hDEADBEEF);
    chk("ws3_ovr", 32'(b3.overrun), 32'd1);

    for (int n = 0; n < 200; n++) begin
      issue(0, ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom()),
            {20'($urandom()), 6'd0, 4'($urandom())}, $urandom());
      idle($urandom_range(0, 2));
    end
    for (int n = 0; n < 200; n++) begin
      issue(1, ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom()),
            {20'($urandom()), 6'd0, 4'($urandom())}, $urandom());
      idle($urandom_range(0, 4));
    end
    idle(6);

    // Reset two cycles into a waited write: write sticks, response is dropped.
    chk("ovr3_before_rst", 32'(b3.overrun), 32'd1);
    issue(1, 4'hF, 30'd9, 32'h12345678);
    idle(1);
    reset3 = 1'b0;
    q3.delete();
    last_acc[1] = -100;
    exp_ovr[1]  = 1'b0;
    last_rd[1]  = 32'd0;
    idle(2);
    reset3 = 1'b1;
    chk("midrst_ready", 32'(b3.mem_ready), 32'd0);
    chk("midrst_rdata", b3.rdata, 32'd0);
    idle(6);
    issue(1, 4'h0, 30'd9, 32'h0);
    idle(5);
    chk("midrst_write_kept", b3.rdata, 32'h12345678);
    chk("midrst_ovr", 32'(b3.overrun), 32'd0);

    idle(10);
    chk("drain0", q0.size(), 32'd0);
    chk("drain3", q3.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule
